// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   ADDR_W / INST_W : address and instruction bus widths
//   ZERO_WORD       : all-zero word used for reset and bubbles
//   CHIP_EN/CHIP_DIS: instruction-memory chip-enable levels
//   RST_ACT         : level of rst that means "in reset"
package if_stage_pkg;
  localparam int   ADDR_W    = 32;
  localparam int   INST_W    = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic CHIP_EN   = 1'b1;
  localparam logic CHIP_DIS  = 1'b0;
  localparam logic RST_ACT   = 1'b0;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  // Word-align a redirect target by dropping the byte offset.
  function automatic addr_t align(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic misaligned(input addr_t a);
    return |a[1:0];
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   ce     : chip enable, driven by fetch
//   pc     : fetch address, driven by fetch
//   inst_i : instruction for pc, returned combinationally by memory
interface if_stage_if;
  import if_stage_pkg::*;
  logic  ce;
  addr_t pc;
  inst_t inst_i;

  modport master (output ce, output pc, input  inst_i);
  modport slave  (input  ce, input  pc, output inst_i);
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with a one-deep pending-redirect slot.
//   clk, rst          : clock, synchronous active-low reset
//   stall_pc          : hold pc this cycle
//   flush, new_pc     : exception redirect, highest priority, works while stalled
//   branch_flag/target: taken branch; parked in the pending slot if stalled
//   ce, pc            : chip enable and fetch address
//   mis               : a misaligned redirect target is being accepted this cycle
module pc_reg
  import if_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  stall_pc,
  input  logic  flush,
  input  addr_t new_pc,
  input  logic  branch_flag,
  input  addr_t branch_target,
  output logic  ce,
  output addr_t pc,
  output logic  mis
);
  logic  pend_vld, pv_nxt;
  addr_t pend_tgt, pt_nxt, pc_nxt;

  always_comb begin
    pc_nxt = pc;
    pv_nxt = pend_vld;
    pt_nxt = pend_tgt;
    mis    = 1'b0;
    // While ce is still low (first edge after reset release) pc stays at 0.
    if (ce == CHIP_EN) begin
      if (flush) begin
        pc_nxt = align(new_pc);
        pv_nxt = 1'b0;
        mis    = misaligned(new_pc);
      end else if (!stall_pc) begin
        if (pend_vld) begin
          pc_nxt = pend_tgt;
          pv_nxt = 1'b0;
        end else if (branch_flag) begin
          pc_nxt = align(branch_target);
          mis    = misaligned(branch_target);
        end else begin
          pc_nxt = pc + ADDR_W'(4);
        end
      end else if (branch_flag) begin
        // Stalled branch: remember it; a newer one overwrites the older.
        pt_nxt = align(branch_target);
        pv_nxt = 1'b1;
        mis    = misaligned(branch_target);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      ce       <= CHIP_DIS;
      pc       <= ZERO_WORD;
      pend_vld <= 1'b0;
      pend_tgt <= ZERO_WORD;
    end else begin
      ce       <= CHIP_EN;
      pc       <= pc_nxt;
      pend_vld <= pv_nxt;
      pend_tgt <= pt_nxt;
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: pc generation plus the IF/ID pipeline register.
//   clk, rst            : clock, synchronous active-low reset
//   stall_pc, stall_id  : hold pc / hold IF/ID register
//   flush, new_pc       : exception redirect (bubbles IF/ID)
//   branch_flag/_target : taken-branch redirect from decode
//   imem                : instruction-memory bus (ce, pc out; inst_i in)
//   id_pc/id_inst/id_valid : registered IF/ID contents
//   addr_err            : one-cycle pulse after a misaligned redirect target
module if_stage
  import if_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  stall_pc,
  input  logic  stall_id,
  input  logic  flush,
  input  addr_t new_pc,
  input  logic  branch_flag,
  input  addr_t branch_target,
  if_stage_if.master imem,
  output addr_t id_pc,
  output inst_t id_inst,
  output logic  id_valid,
  output logic  addr_err
);
  logic  ce, mis;
  addr_t pc;

  pc_reg u_pc (
    .clk(clk), .rst(rst), .stall_pc(stall_pc),
    .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .ce(ce), .pc(pc), .mis(mis)
  );

  assign imem.ce = ce;
  assign imem.pc = pc;

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      id_pc    <= ZERO_WORD;
      id_inst  <= ZERO_WORD;
      id_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= mis;
      // pc is held but decode is free: feed it a bubble rather than a duplicate.
      if (flush || (stall_pc && !stall_id)) begin
        id_pc    <= ZERO_WORD;
        id_inst  <= ZERO_WORD;
        id_valid <= 1'b0;
      end else if (!stall_id) begin
        id_pc    <= pc;
        id_inst  <= imem.inst_i;
        id_valid <= ce;
      end
    end
  end
endmodule
